// File: rtl/synchronization_core_stage3.sv
// Barrier synchronization core, stage 3: applies an account message to its barrier
// record, writes the record back to stage 2 and queues release messages toward the NI.

package synchronization_core_stage3_pkg;

  localparam int ID_W   = 6;
  localparam int TILE_W = 3;
  localparam int MASK_W = 1 << TILE_W;
  localparam int CNT_W  = 4;

  typedef struct packed {
    logic [ID_W-1:0]   id_barrier;
    logic [TILE_W-1:0] tile_id_source;
    logic [CNT_W-1:0]  cnt_setup;
  } sync_account_message_t;

  typedef struct packed {
    logic [CNT_W-1:0]  cnt;
    logic [MASK_W-1:0] mask_slave;
  } barrier_data_t;

endpackage

module synchronization_core_stage3
  import synchronization_core_stage3_pkg::*;
#(
  parameter int TILE_ID            = 0,
  parameter int RELEASE_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ss2_account_valid,
  input  sync_account_message_t ss2_account_mess,
  input  logic                  ss2_mem_valid,
  input  barrier_data_t         ss2_barrier_mem_read,
  output logic                  ss3_account_pending_valid,
  output sync_account_message_t ss3_account_pending,
  output barrier_data_t         ss3_barrier_mem_write,
  output logic                  ss3_release_barrier,
  output logic                  ss3_release_valid,
  output logic [ID_W-1:0]       ss3_release_id,
  output logic [MASK_W-1:0]     ss3_release_mask,
  input  logic                  ni_release_ready,
  output logic                  ss3_release_almost_full,
  output logic                  ss3_error
);

  localparam int PTR_W   = $clog2(RELEASE_FIFO_DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int ENTRY_W = ID_W + MASK_W;

  // Illegal configurations leave a marker block in the elaborated hierarchy.
  if (RELEASE_FIFO_DEPTH < 4 ||
      (RELEASE_FIFO_DEPTH & (RELEASE_FIFO_DEPTH - 1)) != 0 ||
      TILE_ID < 0) begin : g_illegal_config
  end

  // Forward register: last write-back, covering the BRAM read-during-write gap.
  logic                 fwd_valid_q, fwd_valid_d;
  logic [ID_W-1:0]      fwd_id_q, fwd_id_d;
  barrier_data_t        fwd_data_q, fwd_data_d;
  logic                 fwd_release_q, fwd_release_d;

  logic [ENTRY_W-1:0]   fifo_mem_q [RELEASE_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic                 almost_full_q, almost_full_d;
  logic                 error_q, error_d;

  logic                 fwd_hit;
  barrier_data_t        eff_data;
  logic                 eff_valid;
  logic [MASK_W-1:0]    onehot;
  logic [CNT_W-1:0]     setup;
  logic                 dup;
  barrier_data_t        wr_data;
  logic                 release_now;
  logic                 proto_err;

  logic                 fifo_full;
  logic                 head_valid;
  logic                 push_ok;
  logic                 pop;
  logic                 overflow;

  always_comb begin
    fwd_hit   = ss2_account_valid & fwd_valid_q &
                (fwd_id_q == ss2_account_mess.id_barrier);
    eff_data  = fwd_hit ? fwd_data_q : ss2_barrier_mem_read;
    eff_valid = fwd_hit ? ~fwd_release_q : ss2_mem_valid;
    onehot    = MASK_W'(1) << ss2_account_mess.tile_id_source;
    setup     = (ss2_account_mess.cnt_setup == '0) ? CNT_W'(1)
                                                   : ss2_account_mess.cnt_setup;
    dup       = eff_valid & (|(eff_data.mask_slave & onehot));

    wr_data = eff_data;
    if (!eff_valid) begin
      wr_data.cnt        = setup - CNT_W'(1);
      wr_data.mask_slave = onehot;
    end else if (!dup) begin
      wr_data.cnt        = eff_data.cnt - CNT_W'(1);
      wr_data.mask_slave = eff_data.mask_slave | onehot;
    end

    release_now = ss2_account_valid & ~dup & (wr_data.cnt == '0);
    proto_err   = ss2_account_valid &
                  ((~eff_valid & (ss2_account_mess.cnt_setup == '0)) | dup);
  end

  assign ss3_account_pending_valid = ss2_account_valid;
  assign ss3_account_pending       = ss2_account_mess;
  assign ss3_barrier_mem_write     = ss2_account_valid ? wr_data : '0;
  assign ss3_release_barrier       = release_now;

  always_comb begin
    fwd_valid_d   = fwd_valid_q;
    fwd_id_d      = fwd_id_q;
    fwd_data_d    = fwd_data_q;
    fwd_release_d = fwd_release_q;
    if (ss2_account_valid) begin
      fwd_valid_d   = 1'b1;
      fwd_id_d      = ss2_account_mess.id_barrier;
      fwd_data_d    = wr_data;
      fwd_release_d = release_now;
    end
  end

  // Release FIFO: a push onto a full queue is only accepted alongside a pop.
  always_comb begin
    fifo_full  = (occ_q == OCC_W'(RELEASE_FIFO_DEPTH));
    head_valid = (occ_q != '0);
    pop        = head_valid & ni_release_ready;
    push_ok    = release_now & (~fifo_full | pop);
    overflow   = release_now & fifo_full & ~pop;

    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push_ok, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    almost_full_d = (occ_d >= OCC_W'(RELEASE_FIFO_DEPTH - 2));
    error_d       = error_q | proto_err | overflow;
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= {ss2_account_mess.id_barrier, wr_data.mask_slave};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_valid_q   <= 1'b0;
      fwd_id_q      <= '0;
      fwd_data_q    <= '0;
      fwd_release_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      almost_full_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      fwd_valid_q   <= fwd_valid_d;
      fwd_id_q      <= fwd_id_d;
      fwd_data_q    <= fwd_data_d;
      fwd_release_q <= fwd_release_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      almost_full_q <= almost_full_d;
      error_q       <= error_d;
    end
  end

  // Head is forced to zero when empty so stale storage never reaches the NI.
  assign ss3_release_valid       = head_valid;
  assign ss3_release_id          = head_valid ? fifo_mem_q[rd_ptr_q][ENTRY_W-1:MASK_W] : '0;
  assign ss3_release_mask        = head_valid ? fifo_mem_q[rd_ptr_q][MASK_W-1:0] : '0;
  assign ss3_release_almost_full = almost_full_q;
  assign ss3_error               = error_q;

endmodule

// File: tb/tb_synchronization_core_stage3.sv
// Scoreboard bench for stage 3: a driver plays stage 2 and a behavioural barrier model,
// a monitor checks write-backs, release-FIFO heads and status flags.
module tb_synchronization_core_stage3;
  import synchronization_core_stage3_pkg::*;

  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  acc_valid = 1'b0;
  sync_account_message_t acc_mess = '0;
  logic                  mem_valid = 1'b0;
  barrier_data_t         mem_read = '0;
  logic                  ready = 1'b0;

  logic                  pend_valid;
  sync_account_message_t pend_mess;
  barrier_data_t         mem_write;
  logic                  rel_barrier;
  logic                  rel_valid;
  logic [ID_W-1:0]       rel_id;
  logic [MASK_W-1:0]     rel_mask;
  logic                  almost_full;
  logic                  error;

  synchronization_core_stage3 #(.TILE_ID(0), .RELEASE_FIFO_DEPTH(DEPTH)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .ss2_account_valid         (acc_valid),
    .ss2_account_mess          (acc_mess),
    .ss2_mem_valid             (mem_valid),
    .ss2_barrier_mem_read      (mem_read),
    .ss3_account_pending_valid (pend_valid),
    .ss3_account_pending       (pend_mess),
    .ss3_barrier_mem_write     (mem_write),
    .ss3_release_barrier       (rel_barrier),
    .ss3_release_valid         (rel_valid),
    .ss3_release_id            (rel_id),
    .ss3_release_mask          (rel_mask),
    .ni_release_ready          (ready),
    .ss3_release_almost_full   (almost_full),
    .ss3_error                 (error)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int cnt; int mask; bit rel; } wb_t;
  typedef struct { int id; int mask; } rel_t;

  wb_t  wb_sb[$];
  rel_t rel_sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural barrier table (what the records really are).
  bit m_live [64];
  int m_cnt  [64];
  int m_mask [64];

  // What stage 2 actually read for the previous account (stale on back-to-back).
  bit prev_v = 0;
  int prev_id = 0;
  bit prev_live = 0;
  int prev_cnt = 0;
  int prev_mask = 0;

  int occ_now = 0, occ_next = 0;
  bit err_now = 0, err_next = 0;
  bit rdy_req = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) begin
      m_live[i] = 0; m_cnt[i] = 0; m_mask[i] = 0;
    end
    prev_v = 0;
    occ_now = 0; occ_next = 0;
    err_now = 0; err_next = 0;
    rel_sb.delete();
  endtask

  task automatic cycle(input bit v, input int id, input int tile, input int setup);
    wb_t e;
    int  s;
    bit  dup, rel, pop;
    @(posedge clk); #1;
    occ_now = occ_next;
    err_now = err_next;
    ready = rdy_req;
    acc_valid = v;
    acc_mess.id_barrier = ID_W'(id);
    acc_mess.tile_id_source = TILE_W'(tile);
    acc_mess.cnt_setup = CNT_W'(setup);
    rel = 0;
    if (v) begin
      if (prev_v && prev_id == id) begin
        mem_valid = prev_live;
        mem_read.cnt = CNT_W'(prev_cnt);
        mem_read.mask_slave = MASK_W'(prev_mask);
      end else if (m_live[id]) begin
        mem_valid = 1'b1;
        mem_read.cnt = CNT_W'(m_cnt[id]);
        mem_read.mask_slave = MASK_W'(m_mask[id]);
      end else begin
        mem_valid = 1'b0;
        mem_read = barrier_data_t'($urandom);
      end
      prev_live = m_live[id]; prev_cnt = m_cnt[id]; prev_mask = m_mask[id];
      dup = 0;
      if (!m_live[id]) begin
        s = (setup == 0) ? 1 : setup;
        if (setup == 0) err_next = 1;
        m_cnt[id] = s - 1;
        m_mask[id] = 1 << tile;
      end else if ((m_mask[id] >> tile) & 1) begin
        dup = 1;
        err_next = 1;
      end else begin
        m_cnt[id] = m_cnt[id] - 1;
        m_mask[id] = m_mask[id] | (1 << tile);
      end
      rel = !dup && m_cnt[id] == 0;
      m_live[id] = !rel;
      e.id = id; e.cnt = m_cnt[id]; e.mask = m_mask[id]; e.rel = rel;
      wb_sb.push_back(e);
    end else begin
      mem_valid = 1'($urandom);
      mem_read = barrier_data_t'($urandom);
    end
    prev_v = v;
    prev_id = id;
    pop = rdy_req && occ_now > 0;
    occ_next = occ_now - (pop ? 1 : 0);
    if (rel) begin
      if (occ_now == DEPTH && !pop) begin
        err_next = 1;
      end else begin
        rel_sb.push_back('{id: id, mask: m_mask[id]});
        occ_next = occ_next + 1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    acc_valid = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboards.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_release_valid", 32'(rel_valid), 0);
      check("rst_error", 32'(error), 0);
      check("rst_almost_full", 32'(almost_full), 0);
    end else begin
      wb_t  w;
      rel_t r;
      check("release_valid", 32'(rel_valid), 32'(occ_now != 0));
      check("almost_full", 32'(almost_full), 32'(occ_now >= DEPTH - 2));
      check("error", 32'(error), 32'(err_now));
      if (pend_valid) begin
        if (wb_sb.size() == 0) begin
          check("wb_unexpected", 32'(pend_valid), 0);
        end else begin
          w = wb_sb.pop_front();
          check("wb_id", 32'(pend_mess.id_barrier), 32'(w.id));
          check("wb_cnt", 32'(mem_write.cnt), 32'(w.cnt));
          check("wb_mask", 32'(mem_write.mask_slave), 32'(w.mask));
          check("wb_release", 32'(rel_barrier), 32'(w.rel));
        end
      end else begin
        check("idle_release", 32'(rel_barrier), 0);
      end
      if (rel_valid && ready) begin
        if (rel_sb.size() == 0) begin
          check("rel_unexpected", 32'(rel_valid), 0);
        end else begin
          r = rel_sb.pop_front();
          $display("release pop id=%0d mask=%0h", rel_id, rel_mask);
          check("rel_id", 32'(rel_id), 32'(r.id));
          check("rel_mask", 32'(rel_mask), 32'(r.mask));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    #1;
    check("reset_pend_valid", 32'(pend_valid), 0);
    check("reset_mem_write", 32'(mem_write), 0);
    check("reset_rel_id", 32'(rel_id), 0);
    check("reset_rel_mask", 32'(rel_mask), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Four arrivals to barrier 3 with gaps so stage 2 presents the true record.
    rdy_req = 1;
    for (int t = 0; t < 4; t++) begin
      cycle(1, 3, t, 4);
      #1;
      check("t1_cnt", 32'(mem_write.cnt), 32'(3 - t));
      check("t1_mask", 32'(mem_write.mask_slave), 32'((1 << (t + 1)) - 1));
      check("t1_release", 32'(rel_barrier), 32'(t == 3));
      cycle(0, 0, 0, 0);
    end

    // Back-to-back to id 5: second read is stale, forwarding must apply.
    cycle(1, 5, 1, 2);
    cycle(1, 5, 2, 2);
    #1;
    check("t2_cnt", 32'(mem_write.cnt), 0);
    check("t2_mask", 32'(mem_write.mask_slave), 32'h6);
    check("t2_release", 32'(rel_barrier), 1);
    cycle(0, 0, 0, 0);

    // Single-arrival barrier from tile 7.
    cycle(1, 8, 7, 1);
    #1;
    check("t3_mask", 32'(mem_write.mask_slave), 32'h80);
    check("t3_release", 32'(rel_barrier), 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // Duplicate arrival from tile 2 on a live record.
    cycle(1, 6, 2, 3);
    cycle(0, 0, 0, 0);
    cycle(1, 6, 2, 3);
    #1;
    check("t4_cnt", 32'(mem_write.cnt), 2);
    check("t4_mask", 32'(mem_write.mask_slave), 32'h4);
    check("t4_release", 32'(rel_barrier), 0);
    repeat (3) cycle(0, 0, 0, 0);

    // Fill the release FIFO with ready held low, then overflow it.
    do_reset();
    rdy_req = 0;
    for (int t = 0; t < 5; t++) begin
      cycle(1, 10 + t, 0, 1);
      cycle(0, 0, 0, 0);
    end
    rdy_req = 1;
    repeat (6) cycle(0, 0, 0, 0);

    // Reset with two entries queued and a barrier half way.
    do_reset();
    rdy_req = 0;
    cycle(1, 20, 0, 1);
    cycle(1, 21, 0, 1);
    cycle(1, 9, 3, 3);
    cycle(0, 0, 0, 0);
    do_reset();
    cycle(1, 9, 3, 3);
    #1;
    check("t6_fresh_cnt", 32'(mem_write.cnt), 2);
    check("t6_fresh_mask", 32'(mem_write.mask_slave), 32'h8);
    cycle(0, 0, 0, 0);

    // Randomised traffic over a small id range to stress forwarding and the FIFO.
    for (int i = 0; i < 400; i++) begin
      rdy_req = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 2) != 0) begin
        cycle(1, $urandom_range(0, 3), $urandom_range(0, 7),
              ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4));
      end else begin
        cycle(0, 0, 0, 0);
      end
    end

    rdy_req = 1;
    for (int i = 0; i < 12 && (occ_next != 0 || occ_now != 0); i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    @(negedge clk); #1;
    check("final_rel_sb_empty", 32'(rel_sb.size()), 0);
    check("final_wb_sb_empty", 32'(wb_sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
